// File: rtl/lh_pkg.sv
// lh_pkg: shared state enum, flag bit indices and default timing constants for the lighthouse timer
package lh_pkg;
  localparam int DEF_TIME_W = 32;
  localparam int DEF_SYNC_MIN = 800;
  localparam int DEF_PULSE_MAX = 4000;
  localparam int DEF_CYCLE_TIMEOUT = 128000;
  localparam int FLAG_HAS_B = 0;
  localparam int FLAG_HAS_SWEEP = 1;
  localparam int FLAG_EXTRA = 2;
  localparam int FLAG_OVERRUN = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC_A, ST_WAIT, ST_PULSE} state_t;
endpackage

// File: rtl/lh_channel_timer.sv
// lh_channel_timer: per-sensor synchroniser, sync/sweep classifier and cycle timer (t is the offset of the current cycle from the sync A fall)
module lh_channel_timer
  import lh_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W,
  parameter int SYNC_MIN = DEF_SYNC_MIN,
  parameter int PULSE_MAX = DEF_PULSE_MAX,
  parameter int CYCLE_TIMEOUT = DEF_CYCLE_TIMEOUT,
  localparam int RW = 3 * TIME_W + 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          envelope,
  output logic          publish,
  output logic [RW-1:0] result
);
  localparam logic [TIME_W-1:0] SMIN = TIME_W'(SYNC_MIN);
  localparam logic [TIME_W-1:0] PMAX = TIME_W'(PULSE_MAX);
  localparam logic [TIME_W-1:0] TLAST = TIME_W'(CYCLE_TIMEOUT - 1);
  state_t state;
  logic s1, s2, s3;
  logic [TIME_W-1:0] t, w, start, len, b_time, sweep_time;
  logic has_b, has_sweep, extra;
  logic fall, rise, stuck, timeout;
  logic [3:0] flags;
  assign fall = s3 && !s2;
  assign rise = !s3 && s2;
  assign stuck = !s2 && w >= PMAX;
  assign timeout = t == TLAST;
  always_comb begin
    flags = '0;
    flags[FLAG_HAS_B] = has_b;
    flags[FLAG_HAS_SWEEP] = has_sweep;
    flags[FLAG_EXTRA] = extra;
  end
  assign result = {len, b_time, sweep_time, flags};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3} <= 3'b111;
      state <= ST_IDLE;
      {t, w, start, len, b_time, sweep_time} <= '0;
      {has_b, has_sweep, extra, publish} <= '0;
    end else begin
      {s1, s2, s3} <= {envelope, s1, s2};
      t <= t + 1'b1;
      w <= w + 1'b1;
      publish <= 1'b0;
      case (state)
        ST_IDLE:
          if (fall) begin
            state <= ST_SYNC_A;
            t <= TIME_W'(1);
            w <= TIME_W'(1);
            {b_time, sweep_time} <= '0;
            {has_b, has_sweep, extra} <= '0;
          end
        ST_SYNC_A:
          if (rise) begin
            len <= w;
            state <= w >= SMIN ? ST_WAIT : ST_IDLE;
          end else if (stuck) state <= ST_IDLE;
        ST_WAIT:
          if (timeout) begin
            publish <= 1'b1;
            state <= ST_IDLE;
          end else if (fall) begin
            start <= t;
            w <= TIME_W'(1);
            state <= ST_PULSE;
          end
        ST_PULSE:
          if (timeout) begin
            publish <= 1'b1;
            state <= ST_IDLE;
          end else if (stuck) begin
            extra <= 1'b1;
            state <= ST_WAIT;
          end else if (rise) begin
            state <= ST_WAIT;
            if (w >= SMIN) begin
              if (!has_b && !has_sweep) begin
                b_time <= start;
                has_b <= 1'b1;
              end else extra <= 1'b1;
            end else if (!has_sweep) begin
              sweep_time <= start;
              has_sweep <= 1'b1;
            end else extra <= 1'b1;
          end
      endcase
    end
endmodule

// File: rtl/lh_multi_timer.sv
// lh_multi_timer: N-channel lighthouse timer with per-channel pending slots and a round-robin valid/ready result stream
module lh_multi_timer
  import lh_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int TIME_W = DEF_TIME_W,
  parameter int SYNC_MIN = DEF_SYNC_MIN,
  parameter int PULSE_MAX = DEF_PULSE_MAX,
  parameter int CYCLE_TIMEOUT = DEF_CYCLE_TIMEOUT,
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   envelope,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_channel,
  output logic [TIME_W-1:0] out_sync_a_len,
  output logic [TIME_W-1:0] out_sync_b_time,
  output logic [TIME_W-1:0] out_sweep_time,
  output logic [3:0]        out_flags
);
  localparam int RW = 3 * TIME_W + 4;
  typedef struct packed {
    logic [TIME_W-1:0] len;
    logic [TIME_W-1:0] b_time;
    logic [TIME_W-1:0] sweep_time;
    logic [3:0]        flags;
  } result_t;
  if (N_CH < 1 || N_CH > 16 || 64'(CYCLE_TIMEOUT) >= (64'd1 << TIME_W) || 64'(PULSE_MAX) >= (64'd1 << TIME_W)) begin : g_bad_params
    $error("lh_multi_timer: N_CH must be 1..16 and CYCLE_TIMEOUT/PULSE_MAX must fit in TIME_W bits");
  end
  logic [N_CH-1:0] publish, pend, acc, cand;
  logic [RW-1:0] res [N_CH];
  logic [RW-1:0] slot [N_CH];
  logic [RW-1:0] nxt [N_CH];
  result_t out_q;
  logic [CW-1:0] ptr, grant, sel, idx;
  logic any, hold;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lh_channel_timer #(
      .TIME_W(TIME_W),
      .SYNC_MIN(SYNC_MIN),
      .PULSE_MAX(PULSE_MAX),
      .CYCLE_TIMEOUT(CYCLE_TIMEOUT)
    ) u_timer (
      .clk(clk),
      .rst_n(rst_n),
      .envelope(envelope[i]),
      .publish(publish[i]),
      .result(res[i])
    );
    assign acc[i] = out_valid && out_ready && out_channel == CW'(i);
    assign cand[i] = pend[i] && !acc[i];
    assign nxt[i] = publish[i] ? res[i] | (RW'(cand[i]) << FLAG_OVERRUN) : slot[i];
  end
  always_comb begin
    grant = ptr;
    any = 1'b0;
    idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(ptr) + k) % N_CH);
      if (cand[idx]) begin
        grant = idx;
        any = 1'b1;
      end
    end
  end
  assign hold = out_valid && !out_ready;
  assign sel = hold ? out_channel : grant;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      for (int k = 0; k < N_CH; k++) slot[k] <= '0;
    end else begin
      pend <= publish | cand;
      for (int k = 0; k < N_CH; k++) slot[k] <= nxt[k];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_channel <= '0;
      out_q <= '0;
      ptr <= '0;
    end else begin
      out_valid <= hold || any;
      out_channel <= sel;
      out_q <= nxt[sel];
      if (!hold && any) ptr <= grant == CW'(N_CH - 1) ? '0 : grant + 1'b1;
    end
  assign out_sync_a_len = out_q.len;
  assign out_sync_b_time = out_q.b_time;
  assign out_sweep_time = out_q.sweep_time;
  assign out_flags = out_q.flags;
endmodule
